// File: rtl/persp_pkg.sv
// rtl/persp_pkg.sv - shared types and constants for the perspective datapath
package persp_pkg;

    localparam int X_W          = 10;
    localparam int Y_W          = 9;
    localparam int SCREEN_X_MAX = 639;
    localparam int SCREEN_Y_MAX = 479;
    localparam int CNT_W        = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ARMED  = 2'd2,
        ST_SWAP   = 2'd3
    } persp_state_t;

    // |a - b| <= tol on zero-extended operands; 11 bits holds any x or y difference
    function automatic logic within_tol(input logic [10:0] a,
                                        input logic [10:0] b,
                                        input logic [10:0] tol);
        logic signed [10:0] d;
        logic [10:0]        m;
        d = a - b;
        m = d[10] ? 11'(-d) : 11'(d);
        return (m <= tol);
    endfunction

endpackage

// File: rtl/corner_stability_filter.sv
// rtl/corner_stability_filter.sv - range check and stability filter for corner reports
module corner_stability_filter
    import persp_pkg::*;
#(
    parameter int STABLE_N = 4,
    parameter int TOL      = 2,
    parameter int X_MAX    = SCREEN_X_MAX,
    parameter int Y_MAX    = SCREEN_Y_MAX
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                corners_valid,
    input  logic [3:0][X_W-1:0] cx,
    input  logic [3:0][Y_W-1:0] cy,
    output logic                accept,
    output logic [3:0][X_W-1:0] acc_x,
    output logic [3:0][Y_W-1:0] acc_y,
    output logic [7:0]          reject_cnt
);

    localparam logic [X_W-1:0]   X_LIM = X_W'(X_MAX);
    localparam logic [Y_W-1:0]   Y_LIM = Y_W'(Y_MAX);
    localparam logic [10:0]      TOL_V = 11'(TOL);
    localparam logic [CNT_W-1:0] SN    = CNT_W'(STABLE_N);

    logic [3:0][X_W-1:0] cand_x;
    logic [3:0][Y_W-1:0] cand_y;
    logic [CNT_W-1:0]    stable_cnt;
    logic                in_range;
    logic                all_match;

    // Classify the report: inside the screen, and within tolerance of the candidate
    always_comb begin
        in_range  = 1'b1;
        all_match = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (cx[i] > X_LIM || cy[i] > Y_LIM)
                in_range = 1'b0;
            if (!within_tol({1'b0, cx[i]}, {1'b0, cand_x[i]}, TOL_V))
                all_match = 1'b0;
            if (!within_tol({2'b00, cy[i]}, {2'b00, cand_y[i]}, TOL_V))
                all_match = 1'b0;
        end
    end

    // Candidate, stability count, reject count and the one-cycle accept pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cand_x     <= '0;
            cand_y     <= '0;
            stable_cnt <= '0;
            reject_cnt <= '0;
            accept     <= 1'b0;
        end else begin
            accept <= 1'b0;
            if (corners_valid) begin
                if (!in_range) begin
                    if (reject_cnt != 8'hFF)
                        reject_cnt <= reject_cnt + 8'd1;
                    stable_cnt <= '0;
                end else if (all_match) begin
                    if (stable_cnt != SN) begin
                        stable_cnt <= stable_cnt + CNT_W'(1);
                        accept     <= (stable_cnt == SN - CNT_W'(1));
                    end
                end else begin
                    cand_x     <= cx;
                    cand_y     <= cy;
                    stable_cnt <= CNT_W'(1);
                    accept     <= (SN == CNT_W'(1));
                end
            end
        end
    end

    assign acc_x = cand_x;
    assign acc_y = cand_y;

endmodule

// File: rtl/perspective_ctrl.sv
// rtl/perspective_ctrl.sv - sequences accepted corners into perspective_params and frame-aligned swaps
module perspective_ctrl
    import persp_pkg::*;
#(
    parameter int LATENCY  = 2,
    parameter int STABLE_N = 4,
    parameter int TOL      = 2,
    parameter int X_MAX    = SCREEN_X_MAX,
    parameter int Y_MAX    = SCREEN_Y_MAX
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           corners_valid,
    input  logic [X_W-1:0] cx1,
    input  logic [X_W-1:0] cx2,
    input  logic [X_W-1:0] cx3,
    input  logic [X_W-1:0] cx4,
    input  logic [Y_W-1:0] cy1,
    input  logic [Y_W-1:0] cy2,
    input  logic [Y_W-1:0] cy3,
    input  logic [Y_W-1:0] cy4,
    input  logic           frame_start,
    output logic [X_W-1:0] px1,
    output logic [X_W-1:0] px2,
    output logic [X_W-1:0] px3,
    output logic [X_W-1:0] px4,
    output logic [Y_W-1:0] py1,
    output logic [Y_W-1:0] py2,
    output logic [Y_W-1:0] py3,
    output logic [Y_W-1:0] py4,
    output logic           params_ready,
    output logic           params_swap,
    output logic           busy,
    output logic [7:0]     reject_cnt
);

    localparam logic [CNT_W-1:0] LAT = CNT_W'(LATENCY);

    persp_state_t        state;
    persp_state_t        next_state;
    logic [CNT_W-1:0]    settle_cnt;
    logic                accept;
    logic                pending;
    logic                fs_armed;
    logic                load;
    logic                ready_d;
    logic                swap_d;
    logic                busy_d;
    logic [3:0][X_W-1:0] acc_x;
    logic [3:0][Y_W-1:0] acc_y;
    logic [3:0][X_W-1:0] px_q;
    logic [3:0][Y_W-1:0] py_q;

    corner_stability_filter #(
        .STABLE_N (STABLE_N),
        .TOL      (TOL),
        .X_MAX    (X_MAX),
        .Y_MAX    (Y_MAX)
    ) u_filter (
        .clk           (clk),
        .reset_n       (reset_n),
        .corners_valid (corners_valid),
        .cx            ({cx4, cx3, cx2, cx1}),
        .cy            ({cy4, cy3, cy2, cy1}),
        .accept        (accept),
        .acc_x         (acc_x),
        .acc_y         (acc_y),
        .reject_cnt    (reject_cnt)
    );

    // A pending accept left over from a swap counts as an accept once idle
    assign load = accept || (state == ST_IDLE && pending);

    // State register, registered outputs, frame pulse qualified by ARMED, pending flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            params_ready <= 1'b0;
            params_swap  <= 1'b0;
            busy         <= 1'b0;
            fs_armed     <= 1'b0;
            pending      <= 1'b0;
        end else begin
            state        <= next_state;
            params_ready <= ready_d;
            params_swap  <= swap_d;
            busy         <= busy_d;
            fs_armed     <= frame_start && (state == ST_ARMED);
            pending      <= accept && (state == ST_SWAP);
        end
    end

    // Next state: accept always restarts settling and outranks a frame boundary
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (load) next_state = ST_SETTLE;
            ST_SETTLE: if (!accept && settle_cnt <= CNT_W'(1)) next_state = ST_ARMED;
            ST_ARMED: begin
                if (accept)        next_state = ST_SETTLE;
                else if (fs_armed) next_state = ST_SWAP;
            end
            ST_SWAP:   next_state = accept ? ST_SETTLE : ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Output decode from the next state so the flops present it with the state
    always_comb begin
        ready_d = (next_state == ST_ARMED);
        swap_d  = (next_state == ST_SWAP);
        busy_d  = (next_state != ST_IDLE);
    end

    // Corner outputs move only on an accept; settle counter reloads with them
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            px_q       <= '0;
            py_q       <= '0;
            settle_cnt <= '0;
        end else if (load) begin
            px_q       <= acc_x;
            py_q       <= acc_y;
            settle_cnt <= LAT;
        end else if (state == ST_SETTLE && settle_cnt != '0) begin
            settle_cnt <= settle_cnt - CNT_W'(1);
        end
    end

    assign px1 = px_q[0];
    assign px2 = px_q[1];
    assign px3 = px_q[2];
    assign px4 = px_q[3];
    assign py1 = py_q[0];
    assign py2 = py_q[1];
    assign py3 = py_q[2];
    assign py4 = py_q[3];

endmodule

// File: tb/tb_perspective_ctrl.sv
// tb/tb_perspective_ctrl.sv - table, sequence and randomized checks for perspective_ctrl
module tb_perspective_ctrl;

    localparam int LATENCY  = 2;
    localparam int STABLE_N = 4;
    localparam int TOL      = 2;
    localparam int X_MAX    = 639;
    localparam int Y_MAX    = 479;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       corners_valid;
    logic       frame_start;
    logic [9:0] cx [4];
    logic [8:0] cy [4];
    logic [9:0] px [4];
    logic [8:0] py [4];
    logic       params_ready;
    logic       params_swap;
    logic       busy;
    logic [7:0] reject_cnt;

    int n_cmp    = 0;
    int n_bad    = 0;
    int swap_cnt = 0;
    int bx [4]   = '{100, 500, 520, 90};
    int by [4]   = '{50, 60, 400, 420};
    int pool [3][8] = '{'{100, 500, 520, 90, 50, 60, 400, 420},
                        '{639, 10, 637, 5, 479, 3, 477, 470},
                        '{320, 321, 319, 300, 240, 241, 239, 250}};

    typedef struct {
        int x1;
        int x3;
        int busy;
        int rej;
        int px1;
    } row_t;
    row_t rows [$];

    perspective_ctrl #(
        .LATENCY (LATENCY), .STABLE_N (STABLE_N), .TOL (TOL),
        .X_MAX (X_MAX), .Y_MAX (Y_MAX)
    ) dut (
        .clk (clk), .reset_n (reset_n), .corners_valid (corners_valid),
        .cx1 (cx[0]), .cx2 (cx[1]), .cx3 (cx[2]), .cx4 (cx[3]),
        .cy1 (cy[0]), .cy2 (cy[1]), .cy3 (cy[2]), .cy4 (cy[3]),
        .frame_start (frame_start),
        .px1 (px[0]), .px2 (px[1]), .px3 (px[2]), .px4 (px[3]),
        .py1 (py[0]), .py2 (py[1]), .py3 (py[2]), .py4 (py[3]),
        .params_ready (params_ready), .params_swap (params_swap),
        .busy (busy), .reject_cnt (reject_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (params_swap) swap_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic send(input int x1, input int x3, input bit fs);
        for (int i = 0; i < 4; i++) begin
            cx[i] = 10'(bx[i]);
            cy[i] = 9'(by[i]);
        end
        cx[0] = 10'(x1);
        cx[2] = 10'(x3);
        corners_valid = 1'b1;
        frame_start   = fs;
        tick();
        corners_valid = 1'b0;
        frame_start   = 1'b0;
    endtask

    task automatic arm(input int x1);
        for (int i = 0; i < STABLE_N; i++) send(x1, 520, 1'b0);
        repeat (1 + LATENCY) tick();
        chk("arm_ready", params_ready, 1);
    endtask

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    initial begin
        int sc0;
        reset_n = 1'b0; corners_valid = 1'b0; frame_start = 1'b0;
        for (int i = 0; i < 4; i++) begin cx[i] = '0; cy[i] = '0; end
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            chk("reset_px", px[i], 0);
            chk("reset_py", py[i], 0);
        end
        chk("reset_ready", params_ready, 0);
        chk("reset_swap", params_swap, 0);
        chk("reset_busy", busy, 0);
        chk("reset_rej", reject_cnt, 0);
        reset_n = 1'b1;
        tick();

        // Alternating x1 never settles, a reject restarts the count, then four good reports accept
        for (int i = 0; i < 20; i++) rows.push_back(row_t'{(i % 2) ? 103 : 100, 520, 0, 0, 0});
        for (int i = 0; i < 3; i++)  rows.push_back(row_t'{100, 520, 0, 0, 0});
        rows.push_back(row_t'{100, 640, 0, 1, 0});
        for (int i = 0; i < 3; i++)  rows.push_back(row_t'{100, 520, 0, 1, 0});
        rows.push_back(row_t'{100, 520, 1, 1, 100});
        foreach (rows[r]) begin
            repeat (8) tick();
            send(rows[r].x1, rows[r].x3, 1'b0);
            tick();
            chk("tbl_busy", busy, rows[r].busy);
            chk("tbl_rej", reject_cnt, rows[r].rej);
            chk("tbl_px1", px[0], rows[r].px1);
        end
        chk("acc_py4", py[3], 420);
        chk("acc_ready_t1", params_ready, 0);
        tick();
        chk("acc_ready_t2", params_ready, 0);
        tick();
        chk("acc_ready_t3", params_ready, 1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("fs_swap_f0", params_swap, 0);
        chk("fs_ready_f0", params_ready, 1);
        tick();
        chk("fs_swap_f1", params_swap, 1);
        chk("fs_ready_f1", params_ready, 0);
        chk("fs_busy_f1", busy, 1);
        tick();
        chk("fs_swap_f2", params_swap, 0);
        chk("fs_busy_f2", busy, 0);
        repeat (5) tick();
        chk("fs_swap_count", swap_cnt, 1);

        // Accept while ARMED beats a coincident frame_start
        arm(150);
        for (int i = 0; i < STABLE_N - 1; i++) send(200, 520, 1'b0);
        sc0 = swap_cnt;
        send(200, 520, 1'b1);
        tick();
        chk("prio_px1", px[0], 200);
        chk("prio_busy", busy, 1);
        chk("prio_ready", params_ready, 0);
        chk("prio_swap", params_swap, 0);
        tick();
        tick();
        chk("prio_ready_t3", params_ready, 1);
        chk("prio_noswap", swap_cnt, sc0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        chk("prio_swap_later", params_swap, 1);
        tick();
        chk("prio_swap_count", swap_cnt, sc0 + 1);

        // Accept landing in the SWAP cycle: swap still pulses, then straight to SETTLE
        arm(250);
        for (int i = 0; i < STABLE_N - 1; i++) send(300, 520, 1'b0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        send(300, 520, 1'b0);
        chk("swapacc_swap", params_swap, 1);
        tick();
        chk("swapacc_swap_off", params_swap, 0);
        chk("swapacc_busy", busy, 1);
        chk("swapacc_px1", px[0], 300);
        chk("swapacc_ready", params_ready, 0);
        tick();
        chk("swapacc_ready_t3", params_ready, 0);
        tick();
        chk("swapacc_ready_t4", params_ready, 1);

        // Reset in SETTLE clears everything at once and no swap follows
        for (int i = 0; i < STABLE_N; i++) send(350, 520, 1'b0);
        tick();
        chk("rst_settle_busy", busy, 1);
        sc0 = swap_cnt;
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rst_px", px[i], 0);
            chk("rst_py", py[i], 0);
        end
        chk("rst_ready", params_ready, 0);
        chk("rst_swap", params_swap, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rej", reject_cnt, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (10) tick();
        chk("rst_idle_busy", busy, 0);
        chk("rst_noswap", swap_cnt, sc0);

        // Reject counter saturation
        for (int i = 0; i < 300; i++) begin
            send(100, 640, 1'b0);
            if (i == 253) chk("rej_254", reject_cnt, 254);
            if (i == 254) chk("rej_255", reject_cnt, 255);
        end
        chk("rej_sat", reject_cnt, 255);
        chk("rej_busy", busy, 0);

        // Randomized reports against a plain arithmetic model of the filter
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        begin
            int  cand [8];
            int  pset [8];
            int  epx  [8];
            int  rx   [8];
            int  stab;
            int  rej;
            int  base;
            bit  pend;
            bit  ebusy;
            bit  v;
            bit  oor;
            bit  mt;
            int  k;
            for (int i = 0; i < 8; i++) begin cand[i] = 0; epx[i] = 0; pset[i] = 0; end
            stab = 0; rej = 0; base = 0; pend = 1'b0; ebusy = 1'b0;
            for (int c = 0; c < 600; c++) begin
                v = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 5) == 0) base = int'($urandom_range(0, 2));
                for (int i = 0; i < 8; i++) begin
                    rx[i] = pool[base][i];
                    if ($urandom_range(0, 4) == 0) rx[i] = rx[i] + int'($urandom_range(0, 6)) - 3;
                end
                if ($urandom_range(0, 11) == 0) begin
                    k = int'($urandom_range(0, 7));
                    rx[k] = (k < 4) ? 640 + int'($urandom_range(0, 383))
                                    : 480 + int'($urandom_range(0, 31));
                end
                for (int i = 0; i < 4; i++) begin
                    cx[i] = 10'(rx[i]);
                    cy[i] = 9'(rx[4 + i]);
                end
                corners_valid = v;
                tick();
                corners_valid = 1'b0;

                if (pend) begin
                    epx   = pset;
                    ebusy = 1'b1;
                end
                pend = 1'b0;
                if (v) begin
                    oor = 1'b0;
                    mt  = 1'b1;
                    for (int i = 0; i < 8; i++) begin
                        if (rx[i] > ((i < 4) ? X_MAX : Y_MAX)) oor = 1'b1;
                        if (absd(rx[i], cand[i]) > TOL) mt = 1'b0;
                    end
                    if (oor) begin
                        if (rej < 255) rej++;
                        stab = 0;
                    end else if (mt) begin
                        if (stab < STABLE_N) begin
                            stab++;
                            pend = (stab == STABLE_N);
                        end
                    end else begin
                        cand = rx;
                        stab = 1;
                        pend = (STABLE_N == 1);
                    end
                    if (pend) pset = cand;
                end

                chk("rnd_rej", reject_cnt, rej);
                chk("rnd_busy", busy, int'(ebusy));
                for (int i = 0; i < 4; i++) begin
                    chk("rnd_px", px[i], epx[i]);
                    chk("rnd_py", py[i], epx[4 + i]);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
